my_mc_datapath: RTL

MY_MC_DATAPATH -- requirements
Module: my_mc_datapath

---
 rtl/my_mc_datapath_if.sv | 27 ++
 rtl/my_mc_datapath.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/my_mc_datapath_if.sv
// rtl/my_mc_datapath_if.sv - instruction and data memory handshake bundle
interface my_mc_datapath_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_re;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_re, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_re, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/my_mc_datapath.sv
// rtl/my_mc_datapath.sv - multi-cycle RV32-style datapath, FETCH/DECODE/EXEC/MEM/WB with fault state
module my_mc_datapath #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    my_mc_datapath_if.master bus,
    output logic [31:0] inst_out,
    input  logic [3:0]  ALU_Control,
    input  logic [2:0]  ImmSel,
    input  logic [1:0]  MemtoReg,
    input  logic        ALUSrc_B,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        InverseBranch,
    input  logic        PCOffset,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] PC_out,
    output logic [2:0]  state,
    output logic        retire,
    output logic        bus_err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
    logic        z;
    logic [31:0] wait_cnt;
    logic [31:0] regs [32];

    logic [31:0] imm_gen, opb, alu_res;
    logic [31:0] pc_plus4, tgt, pc_next, wdata;
    logic        taken, misaligned, timeout_hit;
    logic [4:0]  rd;

    // ImmSel: 0 I-type, 1 S-type, 2 B-type, 3 U-type, 4 J-type
    always_comb begin
        imm_gen = {{20{ir[31]}}, ir[31:20]};
        case (ImmSel)
            3'd1: imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'd2: imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'd3: imm_gen = {ir[31:12], 12'b0};
            3'd4: imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_gen = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign opb = ALUSrc_B ? imm_gen : b;

    // ALU_Control: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 pass B
    always_comb begin
        alu_res = a + opb;
        case (ALU_Control)
            4'd1:  alu_res = a - opb;
            4'd2:  alu_res = a & opb;
            4'd3:  alu_res = a | opb;
            4'd4:  alu_res = a ^ opb;
            4'd5:  alu_res = a << opb[4:0];
            4'd6:  alu_res = a >> opb[4:0];
            4'd7:  alu_res = $unsigned($signed(a) >>> opb[4:0]);
            4'd8:  alu_res = {31'b0, $signed(a) < $signed(opb)};
            4'd9:  alu_res = {31'b0, a < opb};
            4'd10: alu_res = opb;
            default: alu_res = a + opb;
        endcase
    end

    assign pc_plus4   = pc + 32'd4;
    assign tgt        = PCOffset ? {alu_out[31:1], 1'b0} : pc + imm;
    assign taken      = Jump | (Branch & (InverseBranch ? ~z : z));
    assign pc_next    = taken ? tgt : pc_plus4;
    assign misaligned = taken & (tgt[1:0] != 2'b00);
    assign rd         = ir[11:7];

    always_comb begin
        wdata = alu_out;
        case (MemtoReg)
            2'd1: wdata = mdr;
            2'd2: wdata = Jump ? pc_plus4 : tgt;
            2'd3: wdata = imm;
            default: wdata = alu_out;
        endcase
    end

    assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt + 32'd1 == WAIT_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            z        <= 1'b0;
            wait_cnt <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        ir    <= bus.imem_rdata;
                        state <= DECODE;
                    end else if (timeout_hit) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    a     <= (ir[19:15] == 5'd0) ? '0 : regs[ir[19:15]];
                    b     <= (ir[24:20] == 5'd0) ? '0 : regs[ir[24:20]];
                    state <= EXEC;
                end
                EXEC: begin
                    // IMM is captured here so ImmSel is only looked at while controls are valid
                    imm     <= imm_gen;
                    alu_out <= alu_res;
                    z       <= (alu_res == 32'd0);
                    if (MemRead | MemWrite) begin
                        wait_cnt <= '0;
                        state    <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        mdr   <= bus.dmem_rdata;
                        state <= WB;
                    end else if (timeout_hit) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WB: begin
                    if (misaligned) begin
                        state <= ERR;
                    end else begin
                        if (RegWrite && rd != 5'd0) regs[rd] <= wdata;
                        pc       <= pc_next;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end
                ERR: state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

    assign bus.imem_req   = (state == FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_we    = (state == MEM) & MemWrite;
    assign bus.dmem_re    = (state == MEM) & MemRead & ~MemWrite;
    assign bus.dmem_addr  = alu_out;
    assign bus.dmem_wdata = b;

    assign inst_out = ir;
    assign PC_out   = pc;
    assign retire   = (state == WB) & ~misaligned;
    assign bus_err  = (state == ERR);
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
endmodule
